// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline sequencer.
//   - state encodings of the pipe_ctrl FSM
//   - default drain length and data-memory wait limit
//   - register-specifier width
//   - control-vector struct driven onto the pipeline registers
package pipe_ctrl_pkg;

  localparam int REG_AW           = 3;
  localparam int DRAIN_CYCLES_DEF = 3;
  localparam int MAX_MEM_WAIT_DEF = 15;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_DRAIN    = 2'b10,
    ST_HALTED   = 2'b11
  } state_t;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_flush;
    logic ex_mem_we;
    logic mem_wb_we;
  } ctrl_t;

  // Everything frozen, nothing flushed.
  localparam ctrl_t CTRL_IDLE = '{default: 1'b0};

  // Normal advance of every stage.
  localparam ctrl_t CTRL_ADV = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0,
                                 id_ex_we: 1'b1, id_ex_flush: 1'b0,
                                 ex_mem_we: 1'b1, mem_wb_we: 1'b1};

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard inputs and pipeline-register controls of the sequencer.
//   master : datapath side (drives hazard info, receives enables/flushes)
//   slave  : pipe_ctrl side
// Optional: PIPE_CTRL_STALL_CNT_EN adds stall_cnt[15:0].
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic              id_valid;
  logic              id_read1;
  logic              id_read2;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              ex_mem_read;
  logic              ex_wreg;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_redirect;
  logic              ex_halt;
  logic              imem_stall;
  logic              dmem_stall;

  logic              pc_we;
  logic              if_id_we;
  logic              if_id_flush;
  logic              id_ex_we;
  logic              id_ex_flush;
  logic              ex_mem_we;
  logic              mem_wb_we;
  logic              halted;
  logic              err;
`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  modport master (
    output id_valid, id_read1, id_read2, id_rs, id_rt,
    output ex_mem_read, ex_wreg, ex_rd, ex_redirect, ex_halt,
    output imem_stall, dmem_stall,
    input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
    input  ex_mem_we, mem_wb_we, halted, err
`ifdef PIPE_CTRL_STALL_CNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  id_valid, id_read1, id_read2, id_rs, id_rt,
    input  ex_mem_read, ex_wreg, ex_rd, ex_redirect, ex_halt,
    input  imem_stall, dmem_stall,
    output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
    output ex_mem_we, mem_wb_we, halted, err
`ifdef PIPE_CTRL_STALL_CNT_EN
    , output stall_cnt
`endif
  );

endinterface

// File: rtl/pipe_ctrl_load_use_detect.sv
// load_use_detect: combinational load-use hazard compare between the
// instruction in ID and a load sitting in ID/EX. Kept separate so the
// forwarding logic can reuse the same compare.
//   in : ex_mem_read, ex_wreg, ex_rd, id_valid, id_read1/2, id_rs, id_rt
//   out: hazard
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic              ex_mem_read,
  input  logic              ex_wreg,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic              id_read1,
  input  logic              id_read2,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              hazard
);

  assign hazard = ex_mem_read & ex_wreg & id_valid &
                  ((id_read1 & (id_rs == ex_rd)) | (id_read2 & (id_rt == ex_rd)));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for the 16-bit 5-stage core.
//   clk, rst : core clock, asynchronous active-high reset
//   pif      : pipe_ctrl_if.slave (hazard inputs, stage enables/flushes,
//              halted, sticky err)
// Enables/flushes are combinational from state and inputs; state, counters,
// halted and err are registered.
// Optional: PIPE_CTRL_STALL_CNT_EN adds pif.stall_cnt, a saturating count of
// non-HALTED cycles with pc_we=0.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue; hazard priority resolution
// MEM_WAIT | data memory busy, whole pipe frozen, wait timeout running
// DRAIN    | halt left EX; only EX/MEM and MEM/WB keep advancing
// HALTED   | core frozen until reset
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int MAX_MEM_WAIT = MAX_MEM_WAIT_DEF
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave pif
);

  localparam int WAIT_W  = $clog2(MAX_MEM_WAIT + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  state_t             state;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [WAIT_W-1:0]  wait_nxt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               halted_r;
  logic               err_r;
  logic               lu_hazard;
  ctrl_t              ctrl;

  load_use_detect u_lud (
    .ex_mem_read (pif.ex_mem_read),
    .ex_wreg     (pif.ex_wreg),
    .ex_rd       (pif.ex_rd),
    .id_valid    (pif.id_valid),
    .id_read1    (pif.id_read1),
    .id_read2    (pif.id_read2),
    .id_rs       (pif.id_rs),
    .id_rt       (pif.id_rt),
    .hazard      (lu_hazard)
  );

  // Stalled-cycle count after this cycle; entering from RUN counts as the first.
  always_comb begin
    wait_nxt = wait_cnt;
    if (state == ST_RUN)
      wait_nxt = WAIT_W'(1);
    else if (wait_cnt != WAIT_W'(MAX_MEM_WAIT))
      wait_nxt = wait_cnt + 1'b1;
  end

  always_comb begin
    ctrl = CTRL_IDLE;
    if (rst) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else begin
      case (state)
        // MEM_WAIT with the stall released falls straight into RUN rules.
        ST_RUN, ST_MEM_WAIT: begin
          if (pif.dmem_stall) begin
            ctrl = CTRL_IDLE;
          end else if (pif.ex_redirect) begin
            ctrl             = CTRL_ADV;
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
          end else if (pif.ex_halt) begin
            ctrl             = CTRL_ADV;
            ctrl.pc_we       = 1'b0;
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
          end else if (lu_hazard) begin
            ctrl             = CTRL_ADV;
            ctrl.pc_we       = 1'b0;
            ctrl.if_id_we    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
          end else if (pif.imem_stall) begin
            ctrl             = CTRL_ADV;
            ctrl.pc_we       = 1'b0;
            ctrl.if_id_flush = 1'b1;
          end else begin
            ctrl = CTRL_ADV;
          end
        end
        ST_DRAIN: begin
          ctrl.id_ex_flush = 1'b1;
          ctrl.ex_mem_we   = ~pif.dmem_stall;
          ctrl.mem_wb_we   = ~pif.dmem_stall;
        end
        default: ctrl = CTRL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      drain_cnt <= '0;
      halted_r  <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      if (state != ST_HALTED && pif.ex_redirect && pif.ex_halt)
        err_r <= 1'b1;
      case (state)
        ST_RUN, ST_MEM_WAIT: begin
          if (pif.dmem_stall) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= wait_nxt;
            if (wait_nxt == WAIT_W'(MAX_MEM_WAIT))
              err_r <= 1'b1;
          end else begin
            wait_cnt <= '0;
            if (pif.ex_halt && !pif.ex_redirect) begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_DRAIN: begin
          if (!pif.dmem_stall) begin
            if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
              state    <= ST_HALTED;
              halted_r <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_HALTED;
          halted_r <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_r <= '0;
    else if (state != ST_HALTED && !ctrl.pc_we && stall_cnt_r != 16'hFFFF)
      stall_cnt_r <= stall_cnt_r + 16'd1;
  end

  assign pif.stall_cnt = stall_cnt_r;
`endif

  assign pif.pc_we       = ctrl.pc_we;
  assign pif.if_id_we    = ctrl.if_id_we;
  assign pif.if_id_flush = ctrl.if_id_flush;
  assign pif.id_ex_we    = ctrl.id_ex_we;
  assign pif.id_ex_flush = ctrl.id_ex_flush;
  assign pif.ex_mem_we   = ctrl.ex_mem_we;
  assign pif.mem_wb_we   = ctrl.mem_wb_we;
  assign pif.halted      = halted_r;
  assign pif.err         = err_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl.
// Each stimulus cycle pushes the expected control vector
// {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_we,
//  halted, err}; the monitor samples mid-cycle and compares.
module tb_pipe_ctrl;

  logic clk;
  logic rst;

  pipe_ctrl_if pif ();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .pif (pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] e;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [8:0] RS  = 9'b001010000;
  localparam logic [8:0] N   = 9'b110101100;
  localparam logic [8:0] LU  = 9'b000111100;
  localparam logic [8:0] RD  = 9'b111111100;
  localparam logic [8:0] HF  = 9'b011111100;
  localparam logic [8:0] IM  = 9'b011101100;
  localparam logic [8:0] ST  = 9'b000000000;
  localparam logic [8:0] DR  = 9'b000011100;
  localparam logic [8:0] DP  = 9'b000010000;
  localparam logic [8:0] HT  = 9'b000000010;
  localparam logic [8:0] ERR = 9'b000000001;

  task automatic clr();
    pif.id_valid    = 1'b0;
    pif.id_read1    = 1'b0;
    pif.id_read2    = 1'b0;
    pif.id_rs       = '0;
    pif.id_rt       = '0;
    pif.ex_mem_read = 1'b0;
    pif.ex_wreg     = 1'b0;
    pif.ex_rd       = '0;
    pif.ex_redirect = 1'b0;
    pif.ex_halt     = 1'b0;
    pif.imem_stall  = 1'b0;
    pif.dmem_stall  = 1'b0;
  endtask

  // Inputs are already applied at this negedge; record what the cycle must show.
  task automatic cyc(input logic [8:0] e, input string nm);
    exp_t it;
    it.e  = e;
    it.nm = nm;
    exp_q.push_back(it);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t       it;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
        it  = exp_q.pop_front();
        act = {pif.pc_we, pif.if_id_we, pif.if_id_flush, pif.id_ex_we, pif.id_ex_flush,
               pif.ex_mem_we, pif.mem_wb_we, pif.halted, pif.err};
        checks++;
        if (act !== it.e) begin
          errors++;
          $display("FAIL %s: got %b expected %b", it.nm, act, it.e);
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b1;
    clr();
    @(negedge clk);
    cyc(RS, "reset");
    rst = 1'b0;
    cyc(N, "run0");
    cyc(N, "run1");

    pif.ex_mem_read = 1; pif.ex_wreg = 1; pif.ex_rd = 3;
    pif.id_valid = 1; pif.id_read2 = 1; pif.id_rt = 3;
    cyc(LU, "lu_rt");
    clr();
    cyc(N, "lu_rt_clear");

    pif.ex_mem_read = 1; pif.ex_wreg = 1; pif.ex_rd = 5;
    pif.id_valid = 1; pif.id_read1 = 1; pif.id_rs = 5; pif.id_rt = 5;
    cyc(LU, "lu_rs");
    pif.id_valid = 0;
    cyc(N, "lu_no_valid");
    pif.id_valid = 1; pif.ex_wreg = 0;
    cyc(N, "lu_no_wreg");
    pif.ex_wreg = 1; pif.id_read1 = 0;
    cyc(N, "lu_no_read");
    pif.id_read1 = 1; pif.id_rs = 4;
    cyc(N, "lu_rs_diff");
    pif.id_rs = 5; pif.ex_redirect = 1;
    cyc(RD, "lu_redirect");

    clr(); pif.imem_stall = 1;
    cyc(IM, "imem");
    pif.ex_redirect = 1;
    cyc(RD, "imem_redirect");
    clr();
    cyc(N, "imem_clear");

    pif.dmem_stall = 1; pif.ex_redirect = 1;
    cyc(ST, "dmem_over_redirect");
    pif.ex_redirect = 0;
    cyc(ST, "dmem_wait1");
    cyc(ST, "dmem_wait2");
    pif.dmem_stall = 0; pif.ex_redirect = 1;
    cyc(RD, "mem_wait_exit_redirect");
    clr();
    cyc(N, "after_wait");

    pif.ex_halt = 1;
    cyc(HF, "halt_flush");
    clr();
    cyc(DR, "drain0");
    cyc(DR, "drain1");
    pif.dmem_stall = 1;
    cyc(DP, "drain_paused");
    pif.dmem_stall = 0;
    cyc(DR, "drain2");
    cyc(HT, "halted");
    pif.ex_redirect = 1; pif.ex_halt = 1; pif.imem_stall = 1;
    cyc(HT, "halted_ignore");
    cyc(HT, "halted_no_err");

    clr(); rst = 1;
    cyc(RS, "reset2");
    rst = 0;
    cyc(N, "run_after_halt_rst");
    pif.ex_halt = 1;
    cyc(HF, "halt_flush2");
    clr();
    cyc(DR, "drain_before_rst");
    rst = 1;
    cyc(RS, "rst_mid_drain");
    rst = 0;
    cyc(N, "run_after_drain_rst");

    pif.ex_redirect = 1; pif.ex_halt = 1;
    cyc(RD, "redirect_and_halt");
    clr();
    cyc(N | ERR, "err_redirect_halt");

    rst = 1;
    cyc(RS, "reset3");
    rst = 0;
    pif.dmem_stall = 1;
    for (int i = 1; i <= 20; i++)
      cyc((i >= 16) ? (ST | ERR) : ST, $sformatf("dmem_stall_%0d", i));
    pif.dmem_stall = 0;
    cyc(N | ERR, "dmem_release");
    cyc(N | ERR, "err_sticky");

    rst = 1;
    cyc(RS, "reset4");
    rst = 0;
    cyc(N, "run_pre_cnt");
    pif.imem_stall = 1;
    for (int i = 0; i < 4; i++)
      cyc(IM, "imem_cnt");
    clr();
    pif.ex_mem_read = 1; pif.ex_wreg = 1; pif.ex_rd = 2;
    pif.id_valid = 1; pif.id_read1 = 1; pif.id_rs = 2;
    cyc(LU, "lu_cnt");
    clr();
    cyc(N, "run_post_cnt");
`ifdef PIPE_CTRL_STALL_CNT_EN
    #4;
    checks++;
    if (pif.stall_cnt !== 16'd5) begin
      errors++;
      $display("FAIL stall_cnt: got %0d expected 5", pif.stall_cnt);
    end
    @(negedge clk);
`endif

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
